// File: rtl/boid_pkg.sv
// Shared constants and FSM encoding for the boid display path.
// The top-level wrapper and the VGA read path use these as well.
package boid_pkg;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int ADDR_WIDTH   = $clog2(PIXEL_COUNT);
    localparam int MAX_BOIDS    = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAW  = 3'd3,
        ST_SWAP  = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/pixel_addr_calc.sv
// Bounds check and linear framebuffer address for one pixel, one register stage.
// The row multiply is a shift-add over the set bits of the line width.
module pixel_addr_calc #(
    parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
    parameter int ADDR_WIDTH   = boid_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    output logic                  in_bounds,
    output logic [ADDR_WIDTH-1:0] addr
);
    import boid_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(VIDEO_WIDTH);

    logic                  in_bounds_d;
    logic                  in_bounds_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] row_base_s;

    // For 640 this folds to (y<<9)+(y<<7); clipped pixels park the address at 0.
    always_comb begin
        row_base_s = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (ROW_STRIDE[i]) begin
                row_base_s = row_base_s + (ADDR_WIDTH'(y) << i);
            end else begin
                row_base_s = row_base_s;
            end
        end
        in_bounds_d = en && (x < 11'(VIDEO_WIDTH)) && (y < 10'(VIDEO_HEIGHT));
        if (in_bounds_d) begin
            addr_d = row_base_s + ADDR_WIDTH'(x);
        end else begin
            addr_d = '0;
        end
    end

    // Output register keeps write enable and address aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_bounds_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            in_bounds_q <= in_bounds_d;
            addr_q      <= addr_d;
        end
    end

    assign in_bounds = in_bounds_q;
    assign addr      = addr_q;

endmodule

// File: rtl/boid_frame_writer.sv
// Per-frame scheduler: clear back buffer, draw a clipped square sprite per boid,
// then present the frame. Frame time is fixed regardless of boid positions.
module boid_frame_writer #(
    parameter int NUM_BOIDS    = boid_pkg::MAX_BOIDS,
    parameter int IDX_BITS     = $clog2(NUM_BOIDS),
    parameter int SPRITE_SIZE  = 2,
    parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
    parameter int ADDR_WIDTH   = boid_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  screen_end,
    input  logic [9:0]            boid_x,
    input  logic [8:0]            boid_y,
    output logic [IDX_BITS-1:0]   boid_sel,
    output logic                  fb_clear,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_wdata,
    output logic                  fb_swap,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_count
);
    import boid_pkg::*;

    localparam logic [1:0]          PIX_LAST  = 2'(SPRITE_SIZE - 1);
    localparam logic [IDX_BITS-1:0] BOID_LAST = IDX_BITS'(NUM_BOIDS - 1);

    fsm_state_e          state_d, state_q;
    logic [IDX_BITS-1:0] boid_sel_d, boid_sel_q;
    logic [1:0]          dx_d, dx_q;
    logic [1:0]          dy_d, dy_q;
    logic [9:0]          x_lat_d, x_lat_q;
    logic [8:0]          y_lat_d, y_lat_q;
    logic                fb_clear_d, fb_clear_q;
    logic                fb_swap_d, fb_swap_q;
    logic                busy_d, busy_q;
    logic                overrun_d, overrun_q;
    logic [15:0]         frame_count_d, frame_count_q;

    logic                pix_en_s;
    logic [10:0]         pix_x_s;
    logic [9:0]          pix_y_s;

    // Next-state logic. The pixel shown in the next cycle is issued one cycle early
    // so the registered write lines up with the DRAW cycle that owns it.
    always_comb begin
        state_d       = state_q;
        boid_sel_d    = boid_sel_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        x_lat_d       = x_lat_q;
        y_lat_d       = y_lat_q;
        fb_clear_d    = 1'b0;
        fb_swap_d     = 1'b0;
        busy_d        = busy_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        pix_en_s      = 1'b0;
        pix_x_s       = 11'd0;
        pix_y_s       = 10'd0;

        if (screen_end && busy_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (screen_end) begin
                    state_d    = ST_CLEAR;
                    busy_d     = 1'b1;
                    fb_clear_d = 1'b1;
                    boid_sel_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d  = ST_DRAW;
                x_lat_d  = boid_x;
                y_lat_d  = boid_y;
                dx_d     = 2'd0;
                dy_d     = 2'd0;
                pix_en_s = 1'b1;
                pix_x_s  = {1'b0, boid_x};
                pix_y_s  = {1'b0, boid_y};
            end
            ST_DRAW: begin
                if ((dx_q == PIX_LAST) && (dy_q == PIX_LAST)) begin
                    if (boid_sel_q == BOID_LAST) begin
                        state_d       = ST_SWAP;
                        fb_swap_d     = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        state_d    = ST_FETCH;
                        boid_sel_d = boid_sel_q + IDX_BITS'(1);
                    end
                end else begin
                    if (dx_q == PIX_LAST) begin
                        dx_d = 2'd0;
                        dy_d = dy_q + 2'd1;
                    end else begin
                        dx_d = dx_q + 2'd1;
                        dy_d = dy_q;
                    end
                    pix_en_s = 1'b1;
                    pix_x_s  = {1'b0, x_lat_q} + {9'd0, dx_d};
                    pix_y_s  = {1'b0, y_lat_q} + {8'd0, dy_d};
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            boid_sel_q    <= '0;
            dx_q          <= 2'd0;
            dy_q          <= 2'd0;
            x_lat_q       <= 10'd0;
            y_lat_q       <= 9'd0;
            fb_clear_q    <= 1'b0;
            fb_swap_q     <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            boid_sel_q    <= boid_sel_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            x_lat_q       <= x_lat_d;
            y_lat_q       <= y_lat_d;
            fb_clear_q    <= fb_clear_d;
            fb_swap_q     <= fb_swap_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    pixel_addr_calc #(
        .VIDEO_WIDTH  (VIDEO_WIDTH),
        .VIDEO_HEIGHT (VIDEO_HEIGHT),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_pixel_addr (
        .clock     (clock),
        .reset     (reset),
        .en        (pix_en_s),
        .x         (pix_x_s),
        .y         (pix_y_s),
        .in_bounds (fb_we),
        .addr      (fb_addr)
    );

    assign boid_sel    = boid_sel_q;
    assign fb_clear    = fb_clear_q;
    assign fb_wdata    = fb_we;
    assign fb_swap     = fb_swap_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Bench for boid_frame_writer: a 2-boid instance driven from a vector table and a
// default 32-boid instance driven with random positions, both against a pixel model.
module tb_boid_frame_writer;

    localparam int SPR     = 2;
    localparam int PER_BOID = 1 + SPR * SPR;

    typedef struct { int cyc; int addr; } wr_t;
    typedef struct { int x0; int y0; int x1; int y1; int n_wr; int first_addr; } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // small instance (2 boids)
    logic        rst_s = 1'b1, se_s = 1'b0;
    logic [9:0]  bx_s;
    logic [8:0]  by_s;
    logic [0:0]  sel_s;
    logic        clr_s, we_s, wd_s, swp_s, busy_s, ovr_s;
    logic [18:0] addr_s;
    logic [15:0] fc_s;
    int          ps_x[32], ps_y[32];

    // default instance (32 boids)
    logic        rst_f = 1'b1, se_f = 1'b0;
    logic [9:0]  bx_f;
    logic [8:0]  by_f;
    logic [4:0]  sel_f;
    logic        clr_f, we_f, wd_f, swp_f, busy_f, ovr_f;
    logic [18:0] addr_f;
    logic [15:0] fc_f;
    int          pf_x[32], pf_y[32];

    assign bx_s = ps_x[sel_s][9:0];
    assign by_s = ps_y[sel_s][8:0];
    assign bx_f = pf_x[sel_f][9:0];
    assign by_f = pf_y[sel_f][8:0];

    boid_frame_writer #(.NUM_BOIDS(2), .SPRITE_SIZE(SPR)) u_small (
        .clock(clk), .reset(rst_s), .screen_end(se_s), .boid_x(bx_s), .boid_y(by_s),
        .boid_sel(sel_s), .fb_clear(clr_s), .fb_we(we_s), .fb_addr(addr_s),
        .fb_wdata(wd_s), .fb_swap(swp_s), .busy(busy_s), .overrun(ovr_s),
        .frame_count(fc_s)
    );

    boid_frame_writer u_full (
        .clock(clk), .reset(rst_f), .screen_end(se_f), .boid_x(bx_f), .boid_y(by_f),
        .boid_sel(sel_f), .fb_clear(clr_f), .fb_we(we_f), .fb_addr(addr_f),
        .fb_wdata(wd_f), .fb_swap(swp_f), .busy(busy_f), .overrun(ovr_f),
        .frame_count(fc_f)
    );

    wr_t got_s[$], got_f[$], exp_q[$];
    int  clr_q_s[$], swp_q_s[$], clr_q_f[$], swp_q_f[$];
    int  inv_err_s = 0, inv_err_f = 0;
    wr_t w_s, w_f;

    // Event recorders on the falling edge, plus per-cycle output invariants.
    always @(negedge clk) begin
        if (we_s) begin w_s.cyc = cyc; w_s.addr = int'(addr_s); got_s.push_back(w_s); end
        if (clr_s) clr_q_s.push_back(cyc);
        if (swp_s) swp_q_s.push_back(cyc);
        if ((we_s && (clr_s || swp_s || !wd_s || !busy_s))) inv_err_s++;
    end

    always @(negedge clk) begin
        if (we_f) begin w_f.cyc = cyc; w_f.addr = int'(addr_f); got_f.push_back(w_f); end
        if (clr_f) clr_q_f.push_back(cyc);
        if (swp_f) swp_q_f.push_back(cyc);
        if ((we_f && (clr_f || swp_f || !wd_f || !busy_f))) inv_err_f++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input bit full, output int t0);
        if (full) se_f = 1'b1; else se_s = 1'b1;
        t0 = cyc;
        step();
        se_f = 1'b0;
        se_s = 1'b0;
    endtask

    task automatic wait_swap(input bit full, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((full ? swp_q_f.size() : swp_q_s.size()) > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Reference: every sprite pixel of every boid in scan order, one cycle each,
    // starting three cycles after screen_end (clear, fetch, then draw).
    task automatic build_exp(input int n, input int t0, input int xs[32], input int ys[32]);
        wr_t e;
        exp_q.delete();
        for (int b = 0; b < n; b++)
            for (int dy = 0; dy < SPR; dy++)
                for (int dx = 0; dx < SPR; dx++) begin
                    if ((xs[b] + dx) < 640 && (ys[b] + dy) < 480) begin
                        e.cyc  = t0 + 3 + b * PER_BOID + dy * SPR + dx;
                        e.addr = (ys[b] + dy) * 640 + (xs[b] + dx);
                        exp_q.push_back(e);
                    end
                end
    endtask

    task automatic cmp_writes(input string nm, input wr_t got[$], input wr_t exp[$]);
        int bad;
        int n;
        bad = -1;
        chk($sformatf("%s write_count", nm), got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++)
            if (bad < 0 && (got[i].cyc != exp[i].cyc || got[i].addr != exp[i].addr)) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                     nm, bad, got[bad].cyc, got[bad].addr, exp[bad].cyc, exp[bad].addr);
        end
    endtask

    task automatic rand_pos();
        for (int b = 0; b < 32; b++) begin
            pf_x[b] = int'($urandom_range(638, 0));
            pf_y[b] = int'($urandom_range(478, 0));
        end
    endtask

    task automatic full_frame(input string nm, input int ovr_at);
        int t0;
        bit ok;
        got_f.delete(); clr_q_f.delete(); swp_q_f.delete();
        step();
        pulse(1'b1, t0);
        build_exp(32, t0, pf_x, pf_y);
        if (ovr_at > 0) begin
            repeat (ovr_at - 1) step();
            se_f = 1'b1;
            step();
            se_f = 1'b0;
        end
        wait_swap(1'b1, 400, ok);
        chk($sformatf("%s swap_seen", nm), ok, 1);
        if (ok) begin
            chk($sformatf("%s latency", nm), swp_q_f[0] - t0, 162);
            chk($sformatf("%s clear_cycle", nm), (clr_q_f.size() > 0) ? clr_q_f[0] - t0 : -1, 1);
            chk($sformatf("%s busy_at_swap", nm), busy_f, 1);
            cmp_writes(nm, got_f, exp_q);
            chk($sformatf("%s writes_128", nm), got_f.size(), 128);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int  t0;
        bit  ok;
        bit  found;

        vecs[0] = '{10, 10, 700, 10, 4, 6410};
        vecs[1] = '{639, 479, 700, 10, 1, 307199};
        vecs[2] = '{0, 0, 638, 478, 8, 0};
        vecs[3] = '{639, 0, 0, 479, 4, 639};
        vecs[4] = '{1023, 511, 500, 100, 4, 64500};
        vecs[5] = '{0, 479, 639, 479, 3, 306560};

        for (int b = 0; b < 32; b++) begin ps_x[b] = 0; ps_y[b] = 0; pf_x[b] = 0; pf_y[b] = 0; end

        repeat (3) step();
        rst_s = 1'b0;
        rst_f = 1'b0;
        step();
        chk("reset_small", {sel_s, clr_s, we_s, addr_s, wd_s, swp_s, busy_s, ovr_s, fc_s}, 0);
        chk("reset_full",  {sel_f, clr_f, we_f, addr_f, wd_f, swp_f, busy_f, ovr_f, fc_f}, 0);

        // table-driven 2-boid frames
        for (int v = 0; v < 6; v++) begin
            ps_x[0] = vecs[v].x0; ps_y[0] = vecs[v].y0;
            ps_x[1] = vecs[v].x1; ps_y[1] = vecs[v].y1;
            got_s.delete(); clr_q_s.delete(); swp_q_s.delete();
            step();
            pulse(1'b0, t0);
            build_exp(2, t0, ps_x, ps_y);
            wait_swap(1'b0, 40, ok);
            chk($sformatf("v%0d swap_seen", v), ok, 1);
            if (ok) begin
                chk($sformatf("v%0d swap_cycle", v), swp_q_s[0] - t0, 12);
                chk($sformatf("v%0d clear_cycle", v), (clr_q_s.size() > 0) ? clr_q_s[0] - t0 : -1, 1);
                chk($sformatf("v%0d busy_at_swap", v), busy_s, 1);
                cmp_writes($sformatf("v%0d", v), got_s, exp_q);
                chk($sformatf("v%0d n_writes", v), got_s.size(), vecs[v].n_wr);
                chk($sformatf("v%0d first_addr", v), (got_s.size() > 0) ? got_s[0].addr : -1,
                    vecs[v].first_addr);
                step();
                chk($sformatf("v%0d busy_after", v), busy_s, 0);
                chk($sformatf("v%0d frame_count", v), fc_s, v + 1);
                chk($sformatf("v%0d overrun", v), ovr_s, 0);
            end
        end

        // random default frame, then a back-to-back frame accepted right after swap
        rand_pos();
        full_frame("rand1", 0);
        rand_pos();
        full_frame("b2b", 0);
        step();
        chk("b2b frame_count", fc_f, 2);
        chk("b2b overrun", ovr_f, 0);

        // second screen_end 50 cycles into a frame
        rand_pos();
        full_frame("ovr", 50);
        chk("ovr flag", ovr_f, 1);
        repeat (200) step();
        chk("ovr single_swap", swp_q_f.size(), 1);
        chk("ovr single_clear", clr_q_f.size(), 1);
        chk("ovr sticky", ovr_f, 1);
        chk("ovr frame_count", fc_f, 3);

        // reset while drawing boid 5
        rand_pos();
        got_f.delete(); clr_q_f.delete(); swp_q_f.delete();
        step();
        pulse(1'b1, t0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sel_f == 5'd5 && we_f) begin found = 1'b1; break; end
            step();
        end
        chk("rst_mid reached_boid5", found, 1);
        rst_f = 1'b1;
        step();
        chk("rst_mid outputs_zero", {sel_f, clr_f, we_f, addr_f, wd_f, swp_f, busy_f, ovr_f, fc_f}, 0);
        rst_f = 1'b0;
        repeat (200) step();
        chk("rst_mid no_swap", swp_q_f.size(), 0);
        full_frame("post_rst", 0);
        step();
        chk("post_rst frame_count", fc_f, 1);

        chk("invariants_small", inv_err_s, 0);
        chk("invariants_full", inv_err_f, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
